// File: rtl/ahb_burst_sequencer.sv
// Master-side AHB burst sequencer: takes one burst command, arbitrates for the bus,
// drives the address/control phases and reports data-phase and burst completion.
module ahb_burst_sequencer #(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 5
) (
   input  logic              Hclk,
   input  logic              Hreset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [2:0]        cmd_burst,
   input  logic [2:0]        cmd_size,
   input  logic              cmd_write,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              Hgrant,
   input  logic              Hready,
   output logic              Hbusreq,
   output logic [1:0]        Htrans,
   output logic [ADDR_W-1:0] Haddr,
   output logic [2:0]        Hburst,
   output logic [2:0]        Hsize,
   output logic              Hwrite,
   output logic              beat_done,
   output logic              burst_done
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_ADDR, S_LAST} state_t;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   wmask_q, wmask_d;
   logic [2:0]          burst_q, burst_d;
   logic [2:0]          size_q, size_d;
   logic                write_q, write_d;
   logic                wrap_q, wrap_d;
   logic                nonseq_q, nonseq_d;
   logic                pend_q, pend_d;
   logic [4:0]          rem_q, rem_d;
   logic [4:0]          cmd_beats;

   function automatic logic [4:0] beat_count(input logic [2:0] burst, input logic [LEN_W-1:0] len);
      logic [4:0] n;
      case (burst)
         3'b000:         n = 5'd1;
         3'b001: begin
            if (32'(len) == 32'd0)     n = 5'd1;
            else if (32'(len) > 32'd16) n = 5'd16;
            else                        n = 5'(len);
         end
         3'b010, 3'b011: n = 5'd4;
         3'b100, 3'b101: n = 5'd8;
         default:        n = 5'd16;
      endcase
      return n;
   endfunction

   // Wrapping bursts keep the upper address bits fixed and roll the low bits inside the
   // B-byte window; the window survives an INCR re-issue after early termination.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                   input logic [2:0] size,
                                                   input logic wrap,
                                                   input logic [ADDR_W-1:0] mask);
      logic [ADDR_W-1:0] sum;
      sum = addr + (ADDR_W'(1) << size);
      if (wrap) return (addr & ~mask) | (sum & mask);
      return sum;
   endfunction

   assign cmd_beats = beat_count(cmd_burst, cmd_len);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wmask_d  = wmask_q;
      burst_d  = burst_q;
      size_d   = size_q;
      write_d  = write_q;
      wrap_d   = wrap_q;
      nonseq_d = nonseq_q;
      rem_d    = rem_q;
      pend_d   = pend_q;

      if (state_q == S_ADDR && Hready) pend_d = 1'b1;
      else if (Hready)                 pend_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               state_d  = S_REQ;
               addr_d   = cmd_addr;
               burst_d  = cmd_burst;
               size_d   = cmd_size;
               write_d  = cmd_write;
               rem_d    = cmd_beats;
               wrap_d   = (cmd_burst == 3'b010) || (cmd_burst == 3'b100) || (cmd_burst == 3'b110);
               wmask_d  = (ADDR_W'(cmd_beats) << cmd_size) - ADDR_W'(1);
               nonseq_d = 1'b1;
            end
         end
         S_REQ: begin
            if (Hgrant && Hready) state_d = S_ADDR;
         end
         S_ADDR: begin
            if (Hready) begin
               rem_d    = rem_q - 5'd1;
               addr_d   = next_addr(addr_q, size_q, wrap_q, wmask_q);
               nonseq_d = 1'b0;
               if (rem_q == 5'd1) begin
                  state_d = S_LAST;
               end else if (!Hgrant) begin
                  state_d  = S_REQ;
                  burst_d  = 3'b001;
                  nonseq_d = 1'b1;
               end
            end
         end
         default: begin
            if (Hready) state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         wmask_q  <= '0;
         burst_q  <= '0;
         size_q   <= '0;
         write_q  <= 1'b0;
         wrap_q   <= 1'b0;
         nonseq_q <= 1'b0;
         rem_q    <= '0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wmask_q  <= wmask_d;
         burst_q  <= burst_d;
         size_q   <= size_d;
         write_q  <= write_d;
         wrap_q   <= wrap_d;
         nonseq_q <= nonseq_d;
         rem_q    <= rem_d;
         pend_q   <= pend_d;
      end
   end

   assign cmd_ready  = (state_q == S_IDLE) && !Hreset;
   assign Hbusreq    = (state_q == S_REQ) || (state_q == S_ADDR);
   assign Htrans     = (state_q != S_ADDR) ? TR_IDLE : (nonseq_q ? TR_NONSEQ : TR_SEQ);
   assign Haddr      = addr_q;
   assign Hburst     = burst_q;
   assign Hsize      = size_q;
   assign Hwrite     = write_q;
   assign beat_done  = pend_q && Hready;
   assign burst_done = (state_q == S_LAST) && Hready;

endmodule

// File: tb/tb_ahb_burst_sequencer.sv
// Randomized bench for ahb_burst_sequencer against a transaction-level model of
// the expected address list, transfer types and completion pulses.
module tb_ahb_burst_sequencer;

   logic        Hclk;
   logic        Hreset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic [2:0]  cmd_burst;
   logic [2:0]  cmd_size;
   logic        cmd_write;
   logic [4:0]  cmd_len;
   logic        Hgrant;
   logic        Hready;
   logic        Hbusreq;
   logic [1:0]  Htrans;
   logic [31:0] Haddr;
   logic [2:0]  Hburst;
   logic [2:0]  Hsize;
   logic        Hwrite;
   logic        beat_done;
   logic        burst_done;

   int n_checks = 0;
   int n_fail   = 0;

   ahb_burst_sequencer #(.ADDR_W(32), .LEN_W(5)) dut (
      .Hclk(Hclk), .Hreset(Hreset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_burst(cmd_burst), .cmd_size(cmd_size), .cmd_write(cmd_write), .cmd_len(cmd_len),
      .Hgrant(Hgrant), .Hready(Hready), .Hbusreq(Hbusreq), .Htrans(Htrans),
      .Haddr(Haddr), .Hburst(Hburst), .Hsize(Hsize), .Hwrite(Hwrite),
      .beat_done(beat_done), .burst_done(burst_done)
   );

   initial Hclk = 1'b0;
   always #5 Hclk = ~Hclk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One command end to end. drop_at: beat index whose acceptance sees Hgrant low,
   // followed by two more ungranted cycles. stall_at: beat index held with Hready low
   // for two cycles. abort_at: return once that many beats are accepted.
   task automatic run_cmd(input logic [2:0] burst, input logic [31:0] addr, input logic [2:0] size,
                          input logic wr, input logic [4:0] len, input int gp, input int rp,
                          input int drop_at, input int stall_at, input bit hold, input int abort_at);
      logic [31:0] exp_a [0:15];
      logic [31:0] inc, bsz, base;
      int beats, idx, cyc, nbeat, ndone, dcnt, scnt;
      bit wrap, act, pend, term, nonseq, done, g, r, nxt_pend;

      case (burst)
         3'b000: beats = 1;
         3'b001: beats = (len == 0) ? 1 : ((len > 16) ? 16 : int'(len));
         3'b010, 3'b011: beats = 4;
         3'b100, 3'b101: beats = 8;
         default: beats = 16;
      endcase
      wrap = (burst == 3'b010) || (burst == 3'b100) || (burst == 3'b110);
      inc  = 32'd1 << size;
      bsz  = 32'(beats) * inc;
      exp_a[0] = addr;
      for (int i = 1; i < beats; i++) begin
         if (wrap) begin
            base = exp_a[i-1] - (exp_a[i-1] % bsz);
            exp_a[i] = base + ((exp_a[i-1] - base + inc) % bsz);
         end else begin
            exp_a[i] = exp_a[i-1] + inc;
         end
      end

      @(negedge Hclk);
      cmd_addr = addr; cmd_burst = burst; cmd_size = size; cmd_write = wr; cmd_len = len;
      cmd_valid = 1'b1; Hgrant = 1'b0; Hready = 1'b1;
      #1;
      check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      check_eq("busreq_idle", 32'(Hbusreq), 32'd0);
      check_eq("trans_idle", 32'(Htrans), 32'd0);
      @(posedge Hclk);

      idx = 0; act = 0; pend = 0; term = 0; nonseq = 1; done = 0;
      cyc = 0; nbeat = 0; ndone = 0; dcnt = 0; scnt = 0;
      while (!done && cyc < 3000) begin
         @(negedge Hclk);
         cyc++;
         cmd_valid = hold;
         g = ($urandom_range(99) < 32'(gp));
         r = ($urandom_range(99) < 32'(rp));
         if (drop_at > 0 && act && idx == drop_at - 1) begin
            g = 1'b0; r = 1'b1;
         end
         if (drop_at > 0 && !act && idx == drop_at && dcnt < 2) begin
            g = 1'b0; dcnt++;
         end
         if (stall_at >= 0 && act && idx == stall_at && scnt < 2) begin
            r = 1'b0; scnt++;
         end
         Hgrant = g; Hready = r;
         #1;
         check_eq("addr_phase_active", 32'(Htrans != 2'b00), 32'(act));
         check_eq("cmd_ready_busy", 32'(cmd_ready), 32'd0);
         check_eq("busreq", 32'(Hbusreq), 32'(idx < beats));
         if (act) begin
            check_eq("htrans", 32'(Htrans), nonseq ? 32'd2 : 32'd3);
            check_eq("haddr", Haddr, exp_a[idx]);
            check_eq("hburst", 32'(Hburst), term ? 32'd1 : 32'(burst));
            check_eq("hsize", 32'(Hsize), 32'(size));
            check_eq("hwrite", 32'(Hwrite), 32'(wr));
         end
         check_eq("beat_done", 32'(beat_done), 32'(pend && r));
         check_eq("burst_done", 32'(burst_done), 32'(idx == beats && pend && r));
         nbeat += int'(beat_done);
         ndone += int'(burst_done);

         if (idx == beats && pend && r) done = 1;
         nxt_pend = (act && r) ? 1'b1 : (r ? 1'b0 : pend);
         if (act) begin
            if (r) begin
               idx++;
               nonseq = 0;
               if (idx == beats) begin
                  act = 0;
               end else if (!g) begin
                  act = 0; term = 1; nonseq = 1;
               end
            end
         end else if (idx < beats && g && r) begin
            act = 1;
         end
         pend = nxt_pend;
         if (abort_at >= 0 && idx == abort_at) break;
      end

      if (abort_at < 0) begin
         check_eq("burst_completed", 32'(done), 32'd1);
         check_eq("beat_done_total", 32'(nbeat), 32'(beats));
         check_eq("burst_done_total", 32'(ndone), 32'd1);
      end
   endtask

   initial begin
      logic [31:0] ra;
      logic [2:0]  rs;
      Hreset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_burst = '0; cmd_size = '0;
      cmd_write = 1'b0; cmd_len = '0; Hgrant = 1'b0; Hready = 1'b1;
      repeat (2) @(posedge Hclk);
      #2;
      check_eq("rst_htrans", 32'(Htrans), 32'd0);
      check_eq("rst_busreq", 32'(Hbusreq), 32'd0);
      check_eq("rst_haddr", Haddr, 32'd0);
      check_eq("rst_hburst", 32'(Hburst), 32'd0);
      check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("rst_beat_done", 32'(beat_done), 32'd0);
      check_eq("rst_burst_done", 32'(burst_done), 32'd0);
      @(negedge Hclk);
      Hreset = 1'b0;

      run_cmd(3'b011, 32'h100, 3'd2, 1'b1, 5'd0, 100, 100, 0, -1, 1'b0, -1);
      run_cmd(3'b010, 32'h38,  3'd2, 1'b0, 5'd0, 100, 100, 0, -1, 1'b0, -1);
      run_cmd(3'b011, 32'h100, 3'd2, 1'b0, 5'd0, 100, 100, 0, 1, 1'b0, -1);
      run_cmd(3'b101, 32'h200, 3'd2, 1'b1, 5'd0, 100, 100, 2, -1, 1'b0, -1);
      run_cmd(3'b001, 32'h40,  3'd1, 1'b0, 5'd0, 100, 100, 0, -1, 1'b0, -1);
      run_cmd(3'b001, 32'h80,  3'd0, 1'b1, 5'd31, 100, 100, 0, -1, 1'b0, -1);
      run_cmd(3'b000, 32'h44,  3'd2, 1'b1, 5'd0, 100, 100, 0, -1, 1'b1, -1);
      run_cmd(3'b000, 32'h48,  3'd2, 1'b0, 5'd0, 100, 100, 0, -1, 1'b0, -1);
      run_cmd(3'b100, 32'h7E,  3'd1, 1'b0, 5'd0, 100, 100, 3, -1, 1'b0, -1);

      // Reset while beat 3 of an INCR16 is on the bus
      run_cmd(3'b111, 32'h400, 3'd2, 1'b1, 5'd0, 100, 100, 0, -1, 1'b0, 2);
      @(posedge Hclk);
      #2;
      check_eq("pre_reset_haddr", Haddr, 32'h408);
      Hreset = 1'b1;
      #1;
      check_eq("mid_rst_htrans", 32'(Htrans), 32'd0);
      check_eq("mid_rst_busreq", 32'(Hbusreq), 32'd0);
      check_eq("mid_rst_haddr", Haddr, 32'd0);
      check_eq("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("mid_rst_beat_done", 32'(beat_done), 32'd0);
      @(negedge Hclk);
      Hreset = 1'b0;
      #1;
      check_eq("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      run_cmd(3'b011, 32'h500, 3'd2, 1'b0, 5'd0, 100, 100, 0, -1, 1'b0, -1);

      for (int k = 0; k < 40; k++) begin
         rs = 3'($urandom_range(2));
         ra = (k % 8 == 7) ? 32'hFFFF_FFF0 : $urandom;
         ra = ra & ~((32'd1 << rs) - 32'd1);
         run_cmd(3'($urandom_range(7)), ra, rs, 1'($urandom_range(1)), 5'($urandom_range(31)),
                 int'($urandom_range(100, 50)), int'($urandom_range(100, 40)), 0, -1, 1'b0, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
